// File: rtl/tug_playfield.sv
// -----------------------------------------------------------------------------
// tug_playfield
//
// Tug of War game engine. Two asynchronous player buttons are synchronized and
// edge-detected into single-cycle press pulses. Each press pulls the single lit
// LED one step toward that player's end of the row. When the light reaches an
// end LED the game freezes with only that LED lit until restart or reset.
//
// Parameters
//   N_LEDS      : LED row length (odd, >= 5). Index N_LEDS-1 is player 1's end.
//   SYNC_STAGES : flip-flop synchronizer depth per button (>= 2).
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (centre, PLAY, synchronizers cleared)
//   restart  : synchronous active-high return to centre / PLAY
//   btn_l    : player 1 button, asynchronous, moves light toward led[N_LEDS-1]
//   btn_r    : player 2 button, asynchronous, moves light toward led[0]
//   led      : one-hot light position (registered)
//   win_l    : game over, player 1 won (registered)
//   win_r    : game over, player 2 won (registered)
// -----------------------------------------------------------------------------
module tug_playfield #(
   parameter int N_LEDS      = 9,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              restart,
   input  logic              btn_l,
   input  logic              btn_r,
   output logic [N_LEDS-1:0] led,
   output logic              win_l,
   output logic              win_r
);

   localparam int POS_W = $clog2(N_LEDS);
   localparam logic [POS_W-1:0] CENTER = POS_W'((N_LEDS - 1) / 2);
   localparam logic [POS_W-1:0] LAST   = POS_W'(N_LEDS - 1);

   typedef enum logic [1:0] {
      PLAY,
      OVER_L,
      OVER_R
   } state_t;

   state_t            state_reg, state_next;
   logic [POS_W-1:0]  pos_reg, pos_next;
   logic [N_LEDS-1:0] led_reg, led_next;
   logic              win_l_reg, win_r_reg;

   // Bit 1 = left player, bit 0 = right player.
   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {btn_l, btn_r};

   // Per-button synchronizer chain followed by a rising-edge detector. The
   // previous-value register resets to 0, so a button held across reset
   // release still registers as exactly one press.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic [SYNC_STAGES-1:0] sync_reg;
         logic                   prev_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               sync_reg <= '0;
               prev_reg <= 1'b0;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
               prev_reg <= sync_reg[SYNC_STAGES-1];
            end
         end

         assign press[gi] = sync_reg[SYNC_STAGES-1] & ~prev_reg;
      end
   endgenerate

   // Next-state / next-position. Restart wins over any press in the same cycle.
   // Simultaneous presses cancel. In PLAY the position never leaves 1..N-2,
   // so a single step can only land on an end, never step past it.
   always_comb begin
      state_next = state_reg;
      pos_next   = pos_reg;
      if (restart) begin
         pos_next   = CENTER;
         state_next = PLAY;
      end else if (state_reg == PLAY) begin
         if (press[1] && !press[0]) begin
            pos_next = pos_reg + POS_W'(1);
         end else if (press[0] && !press[1]) begin
            pos_next = pos_reg - POS_W'(1);
         end
         if (pos_next == LAST) begin
            state_next = OVER_L;
         end else if (pos_next == '0) begin
            state_next = OVER_R;
         end
      end
      led_next = N_LEDS'(1) << pos_next;
   end

   // Outputs are registered from the next-state values so that led and the
   // win flags change on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= PLAY;
         pos_reg   <= CENTER;
         led_reg   <= N_LEDS'(1) << CENTER;
         win_l_reg <= 1'b0;
         win_r_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pos_reg   <= pos_next;
         led_reg   <= led_next;
         win_l_reg <= (state_next == OVER_L);
         win_r_reg <= (state_next == OVER_R);
      end
   end

   assign led   = led_reg;
   assign win_l = win_l_reg;
   assign win_r = win_r_reg;

endmodule

// File: tb/tb_tug_playfield.sv
// -----------------------------------------------------------------------------
// tb_tug_playfield
//
// Self-checking bench for tug_playfield: a table of hand-derived vectors for a
// full left-player win, hand-written sequences for the multi-cycle corners,
// and a randomized run checked against a game-level reference model.
// -----------------------------------------------------------------------------
module tb_tug_playfield;

   localparam int N = 9;
   localparam int S = 2;
   localparam int C = (N - 1) / 2;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         restart;
   logic         btn_l;
   logic         btn_r;
   logic [N-1:0] led;
   logic         win_l;
   logic         win_r;

   always #5 clk = ~clk;

   tug_playfield #(
      .N_LEDS      (N),
      .SYNC_STAGES (S)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart),
      .btn_l   (btn_l),
      .btn_r   (btn_r),
      .led     (led),
      .win_l   (win_l),
      .win_r   (win_r)
   );

   int tests = 0;
   int fails = 0;

   // ---------------- reference model ----------------
   // hl/hr[k] = button level sampled k edges ago (k = 1..S+1). A press takes
   // effect S edges after the first high sample, i.e. when the sample S edges
   // ago is 1 and the one before it is 0.
   bit hl[S+2];
   bit hr[S+2];
   int m_pos;
   int m_win;   // 0 = playing, 1 = player 1 won, 2 = player 2 won

   function automatic void model_reset();
      for (int i = 0; i < S + 2; i++) begin
         hl[i] = 1'b0;
         hr[i] = 1'b0;
      end
      m_pos = C;
      m_win = 0;
   endfunction

   function automatic void model_edge(bit l, bit r, bit rs);
      bit pl;
      bit pr;
      pl = hl[S] && !hl[S+1];
      pr = hr[S] && !hr[S+1];
      for (int i = S + 1; i > 1; i--) begin
         hl[i] = hl[i-1];
         hr[i] = hr[i-1];
      end
      hl[1] = l;
      hr[1] = r;
      if (rs) begin
         m_pos = C;
         m_win = 0;
      end else if (m_win == 0) begin
         if (pl && !pr) m_pos = m_pos + 1;
         else if (pr && !pl) m_pos = m_pos - 1;
         if (m_pos == N - 1) m_win = 1;
         else if (m_pos == 0) m_win = 2;
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_model(string name);
      logic [31:0] exp_led;
      exp_led = 32'd1 << m_pos;
      check({name, "_led"}, 32'(led), exp_led);
      check({name, "_win_l"}, 32'(win_l), 32'(m_win == 1));
      check({name, "_win_r"}, 32'(win_r), 32'(m_win == 2));
   endtask

   // One clock: drive inputs, take the edge, update the model, sample 1 ns later.
   task automatic step(bit l, bit r, bit rs, string name);
      btn_l   = l;
      btn_r   = r;
      restart = rs;
      @(posedge clk);
      model_edge(l, r, rs);
      #1;
      check_model(name);
   endtask

   task automatic press(bit l, bit r, string name);
      repeat (3) step(l, r, 1'b0, name);
      repeat (3) step(1'b0, 1'b0, 1'b0, name);
   endtask

   // Called 1 ns after a rising edge; pulls reset low between edges and checks
   // the asynchronous effect before the next edge.
   task automatic async_reset(string name);
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      check({name, "_led"}, 32'(led), 32'd1 << C);
      check({name, "_win_l"}, 32'(win_l), 32'd0);
      check({name, "_win_r"}, 32'(win_r), 32'd0);
      #2 reset_n = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         l;
      bit         r;
      bit         rs;
      logic [N-1:0] led;
      bit         wl;
      bit         wr;
   } vec_t;

   localparam int NVEC = 42;
   vec_t tbl[NVEC];

   initial begin
      logic [N-1:0] step_led[4];
      bit rl;
      bit rr;
      bit rsr;

      // Left-win walk: 4 presses of 3 high / 3 low, each step landing on the
      // third cycle of the press, then 3 right presses that must be ignored.
      step_led = '{9'b000100000, 9'b001000000, 9'b010000000, 9'b100000000};
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 6; c++) begin
            tbl[p*6+c].l   = (c < 3);
            tbl[p*6+c].r   = 1'b0;
            tbl[p*6+c].rs  = 1'b0;
            tbl[p*6+c].led = (c >= 2) ? step_led[p] :
                             ((p == 0) ? 9'b000010000 : step_led[p-1]);
            tbl[p*6+c].wl  = (p == 3) && (c >= 2);
            tbl[p*6+c].wr  = 1'b0;
         end
      end
      for (int i = 24; i < NVEC; i++) begin
         tbl[i].l   = 1'b0;
         tbl[i].r   = ((i - 24) % 6) < 3;
         tbl[i].rs  = 1'b0;
         tbl[i].led = 9'b100000000;
         tbl[i].wl  = 1'b1;
         tbl[i].wr  = 1'b0;
      end

      // ---- reset ----
      reset_n = 1'b1;
      restart = 1'b0;
      btn_l   = 1'b0;
      btn_r   = 1'b0;
      model_reset();
      #2 reset_n = 1'b0;
      #1;
      check("reset_led", 32'(led), 32'(9'b000010000));
      check("reset_win_l", 32'(win_l), 32'd0);
      check("reset_win_r", 32'(win_r), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (5) step(1'b0, 1'b0, 1'b0, "post_reset");

      // ---- table: left win ----
      for (int i = 0; i < NVEC; i++) begin
         btn_l   = tbl[i].l;
         btn_r   = tbl[i].r;
         restart = tbl[i].rs;
         @(posedge clk);
         model_edge(tbl[i].l, tbl[i].r, tbl[i].rs);
         #1;
         check("tbl_led", 32'(led), 32'(tbl[i].led));
         check("tbl_win_l", 32'(win_l), 32'(tbl[i].wl));
         check("tbl_win_r", 32'(win_r), 32'(tbl[i].wr));
      end

      // ---- restart from OVER_L, with a coinciding right press ----
      step(1'b0, 1'b1, 1'b0, "rs_pre");      // btn_r first sampled
      step(1'b0, 1'b1, 1'b0, "rs_pre");
      step(1'b0, 1'b1, 1'b1, "rs_edge");     // its pulse lands with restart
      check("restart_led", 32'(led), 32'(9'b000010000));
      check("restart_win_l", 32'(win_l), 32'd0);
      repeat (3) step(1'b0, 1'b0, 1'b0, "rs_post");
      check("restart_ignore_led", 32'(led), 32'(9'b000010000));
      press(1'b0, 1'b1, "rs_next");
      check("restart_next_led", 32'(led), 32'(9'b000001000));

      // ---- right win with cancel ----
      step(1'b0, 1'b0, 1'b1, "rw_restart");
      press(1'b0, 1'b1, "rw_p1");
      press(1'b0, 1'b1, "rw_p2");
      check("rw_two_led", 32'(led), 32'(9'b000000100));
      press(1'b1, 1'b1, "rw_cancel");
      check("rw_cancel_led", 32'(led), 32'(9'b000000100));
      press(1'b0, 1'b1, "rw_p3");
      press(1'b0, 1'b1, "rw_p4");
      check("rw_win_led", 32'(led), 32'(9'b000000001));
      check("rw_win_r", 32'(win_r), 32'd1);
      check("rw_win_l", 32'(win_l), 32'd0);

      // ---- held button ----
      step(1'b0, 1'b0, 1'b1, "held_restart");
      repeat (20) step(1'b1, 1'b0, 1'b0, "held");
      repeat (3) step(1'b0, 1'b0, 1'b0, "held_rel");
      check("held_led", 32'(led), 32'(9'b000100000));

      // ---- async reset with a press in flight at pos 6 ----
      step(1'b0, 1'b0, 1'b1, "ar_restart");
      press(1'b1, 1'b0, "ar_p1");
      press(1'b1, 1'b0, "ar_p2");
      check("ar_pos6_led", 32'(led), 32'(9'b001000000));
      step(1'b1, 1'b0, 1'b0, "ar_inflight");
      btn_l = 1'b0;
      async_reset("ar_mid");
      repeat (5) step(1'b0, 1'b0, 1'b0, "ar_after");
      check("ar_after_led", 32'(led), 32'(9'b000010000));

      // ---- randomized run against the model ----
      rl = 1'b0;
      rr = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 2) == 0) rl = !rl;
         if ($urandom_range(0, 2) == 0) rr = !rr;
         rsr = ($urandom_range(0, 63) == 0);
         step(rl, rr, rsr, "rand");
         if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tug_playfield.md
# tug_playfield

Game engine for the Tug of War board. Two player buttons pull a single lit LED toward each player's end of a 9-LED row, and the block drives the row directly. When the light reaches an end LED the game freezes with only that LED lit. The downstream winner-display logic reads the two end LEDs (`led[0]`, `led[N_LEDS-1]`) to pick the HEX glyph. This block is the producer of the signals that display logic decodes.

## Interface
- `N_LEDS`, default 9: LED row length. Must be odd and ≥5.
- `SYNC_STAGES`, default 2: depth of the flip-flop synchronizer on each button. Must be ≥2.
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `restart`, input, 1: synchronous active-high clear to the start position. Already synchronous to `clk`.
- `btn_l`, input, 1: left player (player 1) button, active-high, asynchronous to `clk`.
- `btn_r`, input, 1: right player (player 2) button, active-high, asynchronous to `clk`.
- `led`, output, `N_LEDS`: one-hot light position. Index `N_LEDS-1` is the left/player-1 end.
- `win_l`, output, 1: high while the game is over and player 1 has won.
- `win_r`, output, 1: high while the game is over and player 2 has won.

## Operation
- Each button passes through its own `SYNC_STAGES` flip-flop chain, then a rising-edge detector (one register holding the previous synchronized value).
  - Output of this stage: one press pulse, one cycle wide, per 0→1 transition.
  - A held button produces exactly one pulse.
- Position register `pos`: `$clog2(N_LEDS)` bits. `CENTER = (N_LEDS-1)/2`. `led = 1 << pos` in every state.
- FSM states: `PLAY`, `OVER_L`, `OVER_R`.
- `PLAY` behaviour:
  - Left pulse only: `pos <= pos+1`.
  - Right pulse only: `pos <= pos-1`.
  - Both pulses in the same cycle: no move. The presses cancel.
  - Neither pulse: hold.
  - If the new `pos` equals `N_LEDS-1`, go to `OVER_L` in the same edge.
  - If the new `pos` equals 0, go to `OVER_R` in the same edge.
  - While in `PLAY`, `pos` is always in 1..`N_LEDS-2`, so neither end LED is lit. End LEDs light only in an OVER state.
- `OVER_L` / `OVER_R`:
  - `pos` is frozen and all button pulses are ignored.
  - Exit is only via `restart` or `reset_n`.
- `win_l = (state==OVER_L)`, `win_r = (state==OVER_R)`. Both are registered-state decodes and are never high together.
- `restart` high at an edge, in any state:
  - `pos <= CENTER` and `state <= PLAY`.
  - `restart` has priority over any press pulse in the same cycle.
  - Synchronizer and edge registers are not cleared.
- `reset_n` low, at any time including mid-move:
  - Immediately sets `pos = CENTER` and `state = PLAY`.
  - Clears all synchronizer and previous-value registers to 0.
- Pos arithmetic never wraps: movement stops at the ends by construction because the OVER states freeze it.

## Timing
- Reset values:
  - `led` = one-hot at `CENTER`; for N=9 this is `9'b000010000`.
  - `win_l` = 0, `win_r` = 0.
- Press latency: button first sampled high at rising edge t gives an updated `led` after edge t+`SYNC_STAGES`. With defaults that is 2 cycles.
- Win latency: `win_l`/`win_r` assert on the same edge as the `led` update that reaches the end.
- Minimum press spacing: a button must be low for at least one sampled edge between presses. Toggling faster than `clk` is not counted reliably.
- Button high across reset release: because the edge register resets to 0, this counts as one press. The press takes effect `SYNC_STAGES` edges after the first post-reset edge.
- Restart latency: one edge; `led` shows `CENTER` after the edge at which `restart` is high.

## Test plan
- **Reset:** assert `reset_n`=0 mid-clock with `btn_l`=`btn_r`=0 → immediately `led`=`9'b000010000`, `win_l`=`win_r`=0. Release, run 5 cycles → unchanged.
- **Left win:** 4 separate `btn_l` presses, each 3 cycles high / 3 cycles low.
  - Required: `led` steps through `000100000`, `001000000`, `010000000`, `100000000`.
  - Each step lands 2 cycles after the press is first sampled.
  - `win_l`=1 on the 4th step.
  - Then 3 `btn_r` presses → no change.
- **Right win and cancel:** from `CENTER`, 2 `btn_r` presses → `000000100`.
  - Both buttons rising in the same cycle → no change.
  - 2 more `btn_r` presses → `000000001`, `win_r`=1.
- **Held button:** `btn_l` high for 20 cycles from `CENTER` → exactly one move, to `000100000`.
- **Restart:** in `OVER_L`, pulse `restart` for 1 cycle.
  - Required: `led`=`000010000`, `win_l`=0 after that edge.
  - A `btn_r` press that coincides with `restart` → ignored.
  - The next `btn_r` press → `000001000`.
- **Async reset mid-game:** at pos 6 with a press in flight in the synchronizer, pull `reset_n` low between edges.
  - Required: `led`=`CENTER` immediately.
  - After release with buttons low, no move occurs.
